mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk input 1 (single clock, all state on its rising edge); rst input 1 (asynchronous, active-high reset).
REQ-002 SHALL have upstream ports: in_valid in 1; in_ready out 1; in_addr in 32; in_wdata in 32 (store data or ALU result); in_opcode in 7; in_funct3 in 3; in_rd in 5.
REQ-003 SHALL have LSU-side ports: lsu_ren out 1; lsu_raddr out 32; lsu_wen out 1; lsu_waddr out 32; lsu_wdata out 32; lsu_wmask out 8; lsu_valid in 1; lsu_rdata in 32 (raw word-aligned read word).
REQ-004 SHALL have writeback ports: out_valid out 1; out_ready in 1; out_data out 32; out_rd out 5; out_wen out 1; out_err out 1.

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; in_ready=1 only in IDLE.
REQ-006 Accept (in_valid&in_ready) SHALL register all in_* fields; load (opcode 0000011) or store (0100011) -> ISSUE; any other opcode -> RESP with out_data=in_wdata.
REQ-007 ISSUE SHALL assert exactly one of lsu_ren (load) or lsu_wen (store) for exactly one cycle; store -> RESP next; load -> WAIT next.
REQ-008 WAIT SHALL hold lsu_ren=0, capture lsu_rdata on the cycle lsu_valid=1, then -> RESP; it waits indefinitely otherwise.
REQ-009 RESP SHALL hold out_valid=1 and all out_* stable until out_ready=1, then -> IDLE; no new accept in that same cycle.
REQ-010 Load latency accept->out_valid SHALL be 3 cycles with lsu_valid one cycle after lsu_ren; store 2 cycles; non-memory 1 cycle.
REQ-011 lsu_raddr/lsu_waddr SHALL be {addr[31:2],2'b00}; off=addr[1:0].
REQ-012 Store mask SHALL be: sb 8'h01<<off, sh 8'h03<<off, sw 8'h0F; lsu_wmask[7:4] always 0; lsu_wdata=wdata<<(8*off).
REQ-013 Load result SHALL be w=lsu_rdata>>(8*off), then lb sign-extend w[7:0], lh sign-extend w[15:0], lw w, lbu zero-extend w[7:0], lhu zero-extend w[15:0]; other funct3 -> 0.
REQ-014 Misaligned SHALL mean halfword with off[0]=1 or word with off!=0.
REQ-015 out_wen SHALL be 1 for loads and non-memory ops with rd!=0; 0 for stores, rd=0, or out_err=1; out_rd=registered in_rd.
REQ-016 lsu_* outputs SHALL be registered (driven from state, not from in_*).

Reset
REQ-017 rst=1 SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, out_err=0, out_wen=0, lsu_ren=0, lsu_wen=0, lsu_wmask=0, all data/address registers 0.
REQ-018 Reset during ISSUE/WAIT/RESP SHALL abandon the operation: no lsu_wen pulse, no out_valid, lsu_valid arriving after reset ignored.

Configuration
REQ-019 Macro MEM_MISALIGN_TRAP_EN defined: misaligned load/store SHALL skip ISSUE, go IDLE->RESP with out_err=1, out_wen=0, out_data=in_addr, no LSU access.
REQ-020 MEM_MISALIGN_TRAP_EN undefined: out_err SHALL be tied 0; halfword uses off={addr[1],1'b0}, word uses off=0 (aligned down), access proceeds normally.

Verification
REQ-021 sw addr=0x80000004 wdata=0xDEADBEEF -> one-cycle lsu_wen, lsu_waddr=0x80000004, lsu_wmask=0x0F, lsu_wdata=0xDEADBEEF, out_valid 2 cycles after accept, out_wen=0.
REQ-022 sb addr=0x80000003 wdata=0x000000A5 -> lsu_waddr=0x80000000, lsu_wmask=0x08, lsu_wdata=0xA5000000.
REQ-023 lb addr=0x80000002 rd=5, lsu_rdata=0x12F03456 -> out_data=0xFFFFFFF0, out_rd=5, out_wen=1; lbu same -> 0x000000F0; lhu addr off 2 -> 0x000012F0.
REQ-024 lh addr=0x80000001: with MEM_MISALIGN_TRAP_EN -> no lsu_ren, out_err=1, out_data=0x80000001; without -> lsu_ren, off=0 extraction.
REQ-025 Load with out_ready=0 for 4 cycles in RESP -> out_valid and out_data stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-026 rst asserted in WAIT, lsu_valid=1 one cycle later -> out_valid stays 0, state IDLE, in_ready=1 after rst release.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: load/store pipeline stage with a single-outstanding LSU handshake.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    output logic        lsu_ren,
    output logic [31:0] lsu_raddr,
    output logic        lsu_wen,
    output logic [31:0] lsu_waddr,
    output logic [31:0] lsu_wdata,
    output logic [7:0]  lsu_wmask,
    input  logic        lsu_valid,
    input  logic [31:0] lsu_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic        out_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic accept, is_load, is_store, is_half, is_word, trap;
    logic [1:0] off, off_q;
    logic [2:0] funct3_q;
    logic [3:0] mask4;
    logic [31:0] word_sh, load_val;
    assign in_ready  = state == IDLE;
    assign out_valid = state == RESP;
    assign accept    = in_valid && in_ready;
    assign is_load   = in_opcode == 7'b0000011;
    assign is_store  = in_opcode == 7'b0100011;
    assign is_half   = in_funct3[1:0] == 2'b01;
    assign is_word   = in_funct3[1:0] == 2'b10;
    // Without trapping, halfwords and words are silently aligned down.
    assign off = is_word ? 2'b00 : is_half ? {in_addr[1], 1'b0} : in_addr[1:0];
    assign mask4 = in_funct3[1:0] == 2'b00 ? 4'b0001 << off :
                   is_half ? 4'b0011 << off :
                   is_word ? 4'b1111 : 4'b0000;
`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = (is_load || is_store) &&
                  ((is_half && in_addr[0]) || (is_word && in_addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif
    assign word_sh = lsu_rdata >> {off_q, 3'b000};
    assign load_val = funct3_q == 3'b000 ? {{24{word_sh[7]}}, word_sh[7:0]} :
                      funct3_q == 3'b001 ? {{16{word_sh[15]}}, word_sh[15:0]} :
                      funct3_q == 3'b010 ? word_sh :
                      funct3_q == 3'b100 ? {24'd0, word_sh[7:0]} :
                      funct3_q == 3'b101 ? {16'd0, word_sh[15:0]} : 32'd0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ((is_load || is_store) && !trap) ? ISSUE : RESP;
            ISSUE:   state_nx = lsu_ren ? WAIT : RESP;
            WAIT:    if (lsu_valid) state_nx = RESP;
            RESP:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsu_ren   <= 1'b0;
            lsu_raddr <= '0;
            lsu_wen   <= 1'b0;
            lsu_waddr <= '0;
            lsu_wdata <= '0;
            lsu_wmask <= '0;
            out_data  <= '0;
            out_rd    <= '0;
            out_wen   <= 1'b0;
            out_err   <= 1'b0;
            off_q     <= '0;
            funct3_q  <= '0;
        end else begin
            lsu_ren <= 1'b0;
            lsu_wen <= 1'b0;
            if (accept) begin
                out_rd   <= in_rd;
                funct3_q <= in_funct3;
                off_q    <= off;
                out_err  <= trap;
                out_wen  <= !trap && !is_store && in_rd != 5'd0;
                out_data <= trap ? in_addr : in_wdata;
                if (is_load && !trap) begin
                    lsu_ren   <= 1'b1;
                    lsu_raddr <= {in_addr[31:2], 2'b00};
                end
                if (is_store && !trap) begin
                    lsu_wen   <= 1'b1;
                    lsu_waddr <= {in_addr[31:2], 2'b00};
                    lsu_wdata <= in_wdata << {off, 3'b000};
                    lsu_wmask <= {4'b0000, mask4};
                end
            end
            if (state == WAIT && lsu_valid)
                out_data <= load_val;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against an arithmetic reference model.
module tb_mem_stage;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_ready;
    logic [31:0] in_addr = '0, in_wdata = '0;
    logic [6:0] in_opcode = '0;
    logic [2:0] in_funct3 = '0;
    logic [4:0] in_rd = '0;
    logic lsu_ren, lsu_wen, lsu_valid = 1'b0;
    logic [31:0] lsu_raddr, lsu_waddr, lsu_wdata, lsu_rdata = '0;
    logic [7:0] lsu_wmask;
    logic out_valid, out_ready = 1'b0, out_wen, out_err;
    logic [31:0] out_data;
    logic [4:0] out_rd;
    int n_assert = 0, n_fail = 0;
    logic [31:0] obs_waddr, obs_wdata, obs_data;
    logic [7:0] obs_mask;
    logic obs_wen, obs_err;

    mem_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rd(in_rd),
        .lsu_ren(lsu_ren), .lsu_raddr(lsu_raddr), .lsu_wen(lsu_wen), .lsu_waddr(lsu_waddr),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_valid(lsu_valid), .lsu_rdata(lsu_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
        .out_wen(out_wen), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference: access size from funct3, alignment by modular arithmetic, extension by subtraction.
    task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                         output int lat, output logic e_ren, output logic e_wen,
                         output logic [31:0] e_addr, output logic [31:0] e_wd, output logic [7:0] e_mask,
                         output logic [31:0] e_data, output logic e_owen, output logic e_err);
        int sz, off, eoff;
        longint v;
        bit ld, st, mis, trap;
        ld = op == LD;
        st = op == ST;
        sz = f3[1:0] == 2'd1 ? 2 : f3[1:0] == 2'd2 ? 4 : 1;
        off = int'(addr[1:0]);
        mis = (off % sz) != 0;
        eoff = off - off % sz;
        trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap = (ld || st) && mis;
`endif
        e_err = trap;
        e_ren = ld && !trap;
        e_wen = st && !trap;
        lat = (trap || !(ld || st)) ? 1 : st ? 2 : 3;
        e_addr = addr - 32'(off);
        e_mask = (st && f3 < 3'd3) ? 8'(((1 << sz) - 1) << eoff) : 8'h00;
        e_wd = wdata << (8 * eoff);
        v = longint'(rdata) / (longint'(1) << (8 * eoff));
        v = v % (longint'(1) << (8 * sz));
        if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
            v = 0;
        e_data = trap ? addr : ld ? 32'(v) : wdata;
        e_owen = !trap && !st && rd != 5'd0;
    endtask

    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                       input int hold);
        int lat;
        logic e_ren, e_wen, e_owen, e_err;
        logic [31:0] e_addr, e_wd, e_data;
        logic [7:0] e_mask;
        model(op, f3, addr, wdata, rd, rdata, lat, e_ren, e_wen, e_addr, e_wd, e_mask, e_data, e_owen, e_err);
        @(negedge clk);
        chkb("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_addr = addr; in_wdata = wdata; in_rd = rd;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom; in_funct3 = 3'($urandom);
        for (int i = 1; i <= lat; i++) begin
            if (i > 1) @(negedge clk);
            chkb("out_valid_latency", out_valid, i == lat);
            if (i == 1) begin
                chkb("lsu_ren_issue", lsu_ren, e_ren);
                chkb("lsu_wen_issue", lsu_wen, e_wen);
                if (e_ren) chk("lsu_raddr", lsu_raddr, e_addr);
                if (e_wen) begin
                    chk("lsu_waddr", lsu_waddr, e_addr);
                    chk("lsu_wdata", lsu_wdata, e_wd);
                    chk("lsu_wmask", 32'(lsu_wmask), 32'(e_mask));
                end
                obs_waddr = lsu_waddr; obs_wdata = lsu_wdata; obs_mask = lsu_wmask;
            end
            if (i == 2) begin
                chkb("lsu_ren_single", lsu_ren, 1'b0);
                chkb("lsu_wen_single", lsu_wen, 1'b0);
                lsu_valid = lat == 3;
                lsu_rdata = rdata;
            end else begin
                lsu_valid = 1'b0;
                lsu_rdata = $urandom;
            end
        end
        if (op != ST || e_err) chk("out_data", out_data, e_data);
        chk("out_rd", 32'(out_rd), 32'(rd));
        chkb("out_wen", out_wen, e_owen);
        chkb("out_err", out_err, e_err);
        obs_data = out_data; obs_wen = out_wen; obs_err = out_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chkb("out_valid_hold", out_valid, 1'b1);
            chkb("in_ready_hold", in_ready, 1'b0);
            chk("out_data_hold", out_data, obs_data);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chkb("out_valid_release", out_valid, 1'b0);
        chkb("in_ready_release", in_ready, 1'b1);
    endtask

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        @(negedge clk);
        chkb("rst_in_ready", in_ready, 1'b1);
        chkb("rst_out_valid", out_valid, 1'b0);
        chkb("rst_out_err", out_err, 1'b0);
        chkb("rst_out_wen", out_wen, 1'b0);
        chkb("rst_lsu_ren", lsu_ren, 1'b0);
        chkb("rst_lsu_wen", lsu_wen, 1'b0);
        chk("rst_lsu_wmask", 32'(lsu_wmask), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_lsu_waddr", lsu_waddr, 32'h0);
        rst = 1'b0;

        run(ST, 3'b010, 32'h80000004, 32'hDEADBEEF, 5'd3, 32'h0, 0);
        chk("sw_waddr", obs_waddr, 32'h80000004);
        chk("sw_wmask", 32'(obs_mask), 32'h0F);
        chk("sw_wdata", obs_wdata, 32'hDEADBEEF);
        chkb("sw_out_wen", obs_wen, 1'b0);

        run(ST, 3'b000, 32'h80000003, 32'h000000A5, 5'd1, 32'h0, 0);
        chk("sb_waddr", obs_waddr, 32'h80000000);
        chk("sb_wmask", 32'(obs_mask), 32'h08);
        chk("sb_wdata", obs_wdata, 32'hA5000000);

        run(LD, 3'b000, 32'h80000002, 32'h0, 5'd5, 32'h12F03456, 0);
        chk("lb_data", obs_data, 32'hFFFFFFF0);
        chkb("lb_wen", obs_wen, 1'b1);
        run(LD, 3'b100, 32'h80000002, 32'h0, 5'd5, 32'h12F03456, 0);
        chk("lbu_data", obs_data, 32'h000000F0);
        run(LD, 3'b101, 32'h80000002, 32'h0, 5'd5, 32'h12F03456, 0);
        chk("lhu_data", obs_data, 32'h000012F0);

        run(LD, 3'b001, 32'h80000001, 32'h0, 5'd6, 32'h12348765, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("lh_mis_data", obs_data, 32'h80000001);
        chkb("lh_mis_err", obs_err, 1'b1);
`else
        chk("lh_mis_data", obs_data, 32'hFFFF8765);
        chkb("lh_mis_err", obs_err, 1'b0);
`endif

        run(LD, 3'b010, 32'h80000010, 32'h0, 5'd7, 32'hCAFEBABE, 4);
        chk("lw_hold_data", obs_data, 32'hCAFEBABE);
        run(7'b0110011, 3'b000, 32'h0, 32'h00001234, 5'd9, 32'h0, 1);
        chk("alu_data", obs_data, 32'h00001234);
        run(7'b0010011, 3'b000, 32'h0, 32'h55, 5'd0, 32'h0, 0);
        chkb("alu_rd0_wen", obs_wen, 1'b0);

        // Reset while a load waits for the LSU; the late response must be dropped.
        @(negedge clk);
        in_valid = 1'b1; in_opcode = LD; in_funct3 = 3'b010; in_addr = 32'h80000020; in_rd = 5'd4;
        @(negedge clk);
        in_valid = 1'b0;
        chkb("wait_rst_issue", lsu_ren, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chkb("wait_rst_in_ready_async", in_ready, 1'b1);
        chkb("wait_rst_out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0; lsu_valid = 1'b1; lsu_rdata = 32'h11111111;
        @(negedge clk);
        lsu_valid = 1'b0;
        chkb("wait_rst_no_out", out_valid, 1'b0);
        chkb("wait_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        chkb("wait_rst_no_out2", out_valid, 1'b0);

        // Reset during a store issue cycle cuts the write strobe immediately.
        in_valid = 1'b1; in_opcode = ST; in_funct3 = 3'b010; in_addr = 32'h80000040; in_wdata = 32'h1;
        @(negedge clk);
        in_valid = 1'b0;
        chkb("issue_rst_wen_before", lsu_wen, 1'b1);
        rst = 1'b1;
        #1;
        chkb("issue_rst_wen_async", lsu_wen, 1'b0);
        chk("issue_rst_wmask", 32'(lsu_wmask), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chkb("issue_rst_no_out", out_valid, 1'b0);
        chkb("issue_rst_no_wen", lsu_wen, 1'b0);

        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 2))
                0: begin op = LD; f3 = 3'($urandom_range(0, 7)); end
                1: begin op = ST; f3 = 3'($urandom_range(0, 2)); end
                default: begin op = 7'b0110011; f3 = 3'($urandom); end
            endcase
            run(op, f3, $urandom, $urandom, 5'($urandom), $urandom, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
